// File: rtl/neg_unit_sched_pkg.sv
// ============================================================================
// neg_unit_sched_pkg
// Shared defaults and state encoding for the negate-unit scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package neg_unit_sched_pkg;

  localparam int c_def_num_req = 4;
  localparam int c_def_data_w  = 16;
  localparam int c_def_timeout = 15;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = c_st_idle,
    ST_ISSUE = c_st_issue,
    ST_WAIT  = c_st_wait,
    ST_RESP  = c_st_resp
  } state_t;

endpackage

`default_nettype wire

// File: rtl/neg_unit_sched_rr_arb.sv
// ============================================================================
// rr_arb
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  always_comb begin
    int w_j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    w_j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = int'(ptr) + k;
      if (w_j >= NUM_REQ) begin
        w_j = w_j - NUM_REQ;
      end
      if (!found && req[w_j[IDX_W-1:0]]) begin
        found                  = 1'b1;
        grant[w_j[IDX_W-1:0]]  = 1'b1;
        idx                    = w_j[IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/neg_unit_sched.sv
// ============================================================================
// neg_unit_sched
// Round-robin scheduler sharing one FP16 negate unit among NUM_REQ requesters.
// Optional WAIT timeout enabled by macro NEG_UNIT_SCHED_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module neg_unit_sched
  import neg_unit_sched_pkg::*;
#(
  parameter int NUM_REQ = c_def_num_req,
  parameter int DATA_W  = c_def_data_w,
  parameter int TIMEOUT = c_def_timeout
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         unit_data,
  output logic                      unit_valid,
  input  logic [DATA_W-1:0]         unit_result,
  input  logic                      unit_complete
);

  localparam int c_idx_w = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("neg_unit_sched: unsupported NUM_REQ or TIMEOUT");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_idx_w-1:0]   r_ptr;
  logic [c_idx_w-1:0]   r_owner;
  logic [DATA_W-1:0]    r_unit_data;
  logic [DATA_W-1:0]    r_rsp_data;
  logic [NUM_REQ-1:0]   w_grant;
  logic [c_idx_w-1:0]   w_idx;
  logic                 w_found;
  logic                 w_owner_ready;
  logic                 w_timeout;

  rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_idx_w)
  ) u_rr_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .found (w_found)
  );

  assign w_owner_ready = rsp_ready[r_owner];

`ifdef NEG_UNIT_SCHED_TIMEOUT_EN
  localparam int c_cnt_w = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_rsp_err;

  assign w_timeout = (r_state == ST_WAIT) && (r_cnt == c_cnt_w'(TIMEOUT - 1));
  assign rsp_err   = r_rsp_err;

  // Complete has priority over an expiring count, so err only sets without it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT && !unit_complete) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
      if (r_state == ST_WAIT) begin
        if (unit_complete) begin
          r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_err <= 1'b1;
        end
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    unit_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          req_ready   = w_grant;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        unit_valid  = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (unit_complete || w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = NUM_REQ'(1) << r_owner;
        if (w_owner_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_unit_data <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_unit_data <= req_data[w_idx*DATA_W +: DATA_W];
            r_owner     <= w_idx;
          end
        end
        ST_WAIT: begin
          if (unit_complete) begin
            r_rsp_data <= unit_result;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
          end
        end
        ST_RESP: begin
          if (w_owner_ready) begin
            r_ptr <= (r_owner == c_idx_w'(NUM_REQ - 1)) ? '0 : r_owner + c_idx_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign unit_data = r_unit_data;
  assign rsp_data  = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_neg_unit_sched.sv
// ============================================================================
// tb_neg_unit_sched
// Directed self-checking bench for neg_unit_sched with a one-cycle negate model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neg_unit_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [DATA_W-1:0]         unit_data;
  logic                      unit_valid;
  logic [DATA_W-1:0]         unit_result;
  logic                      unit_complete;

  logic                      model_en;
  logic                      model_complete = 1'b0;
  logic [DATA_W-1:0]         model_result   = '0;
  logic                      spur_complete;

  int checks = 0;
  int errors = 0;
  int rr_order [5] = '{0, 1, 2, 3, 0};

  neg_unit_sched #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .unit_data     (unit_data),
    .unit_valid    (unit_valid),
    .unit_result   (unit_result),
    .unit_complete (unit_complete)
  );

  always #5 clk = ~clk;

  // Standard negate unit: completes one cycle after the issue strobe.
  always @(posedge clk) begin
    model_complete <= model_en & unit_valid;
    model_result   <= unit_data ^ 16'h8000;
  end

  assign unit_complete = model_complete | spur_complete;
  assign unit_result   = spur_complete ? 16'hDEAD : model_result;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = '1;
    model_en = 1'b1; spur_complete = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (unit_valid !== 1'b0) begin errors++; $display("FAIL reset_unit_valid: got %b expected 0", unit_valid); end
    checks++; if (unit_data !== 16'h0000) begin errors++; $display("FAIL reset_unit_data: got %h expected 0000", unit_data); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_round_robin;
    int g;
    req_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    settle;
    for (int n = 0; n < 5; n++) begin
      g = rr_order[n];
      checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, req_ready, 4'(1 << g)); end
      tick; settle;
      checks++; if (unit_data !== 16'(g + 1)) begin errors++; $display("FAIL rr_unit_data%0d: got %h expected %h", n, unit_data, 16'(g + 1)); end
      tick; settle; tick; settle;
      checks++; if (rsp_valid !== 4'(1 << g)) begin errors++; $display("FAIL rr_rsp_valid%0d: got %b expected %b", n, rsp_valid, 4'(1 << g)); end
      checks++; if (rsp_data !== (16'h8000 | 16'(g + 1))) begin errors++; $display("FAIL rr_rsp_data%0d: got %h expected %h", n, rsp_data, 16'h8000 | 16'(g + 1)); end
      if (n == 4) req_valid = '0;
      tick; settle;
    end
  endtask

  task automatic test_single;
    req_data[2*DATA_W +: DATA_W] = 16'h3C00;
    req_valid = 4'b0100; rsp_ready = 4'hF;
    settle;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready: got %b expected 0100", req_ready); end
    tick; req_valid = '0; settle;
    checks++; if (unit_valid !== 1'b1) begin errors++; $display("FAIL single_unit_valid_t1: got %b expected 1", unit_valid); end
    tick; settle;
    checks++; if (unit_valid !== 1'b0) begin errors++; $display("FAIL single_unit_valid_t2: got %b expected 0", unit_valid); end
    tick; settle;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0100", rsp_valid); end
    checks++; if (rsp_data !== 16'hBC00) begin errors++; $display("FAIL single_rsp_data: got %h expected bc00", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %b expected 0", rsp_err); end
    tick; settle;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_done: got %b expected 0000", rsp_valid); end
  endtask

  task automatic test_backpressure;
    req_data[1*DATA_W +: DATA_W] = 16'h1234;
    req_data[0*DATA_W +: DATA_W] = 16'h0055;
    req_valid = 4'b0010; rsp_ready = 4'b1101;
    settle;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b expected 0010", req_ready); end
    tick; req_valid = 4'b0001;
    tick; tick; settle;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_rsp_valid%0d: got %b expected 0010", i, rsp_valid); end
      checks++; if (rsp_data !== 16'h9234) begin errors++; $display("FAIL bp_rsp_data%0d: got %h expected 9234", i, rsp_data); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_grant%0d: got %b expected 0000", i, req_ready); end
      tick; settle;
    end
    rsp_ready = 4'hF;
    tick; settle;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL bp_release: got %b expected 0000", rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant: got %b expected 0001", req_ready); end
    tick; req_valid = '0;
    tick; tick; tick; settle;
  endtask

  task automatic test_spurious;
    spur_complete = 1'b1;
    tick; spur_complete = 1'b0; settle;
    checks++; if (unit_valid !== 1'b0) begin errors++; $display("FAIL spur_idle_unit_valid: got %b expected 0", unit_valid); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL spur_idle_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_data !== 16'h8055) begin errors++; $display("FAIL spur_idle_rsp_data: got %h expected 8055", rsp_data); end
    req_data[2*DATA_W +: DATA_W] = 16'h7E00;
    req_valid = 4'b0100; rsp_ready = 4'b0000;
    settle;
    tick; req_valid = '0;
    tick; tick; settle;
    checks++; if (rsp_data !== 16'hFE00) begin errors++; $display("FAIL spur_resp_data_pre: got %h expected fe00", rsp_data); end
    spur_complete = 1'b1;
    tick; spur_complete = 1'b0; settle;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL spur_resp_valid: got %b expected 0100", rsp_valid); end
    checks++; if (rsp_data !== 16'hFE00) begin errors++; $display("FAIL spur_resp_data: got %h expected fe00", rsp_data); end
    rsp_ready = 4'b0100;
    tick; settle;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL spur_resp_done: got %b expected 0000", rsp_valid); end
    rsp_ready = 4'hF;
  endtask

  task automatic test_reset_mid_wait;
    model_en = 1'b0;
    req_data[3*DATA_W +: DATA_W] = 16'h4321;
    req_valid = 4'b1000;
    settle;
    tick; req_valid = '0;
    tick; settle;
    checks++; if (unit_data !== 16'h4321) begin errors++; $display("FAIL rmw_unit_data_pre: got %h expected 4321", unit_data); end
    rst = 1'b1;
    #1;
    checks++; if (unit_data !== 16'h0000) begin errors++; $display("FAIL rmw_unit_data: got %h expected 0000", unit_data); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL rmw_rsp_data: got %h expected 0000", rsp_data); end
    checks++; if ({req_ready, rsp_valid, unit_valid, rsp_err} !== 10'b0) begin errors++; $display("FAIL rmw_outputs: got %b expected 0", {req_ready, rsp_valid, unit_valid, rsp_err}); end
    tick; rst = 1'b0;
    spur_complete = 1'b1;
    tick; spur_complete = 1'b0; settle;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rmw_late_complete: got %b expected 0000", rsp_valid); end
    model_en = 1'b1;
    req_data[0*DATA_W +: DATA_W] = 16'hC0DE;
    req_valid = 4'hF;
    settle;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmw_first_grant: got %b expected 0001", req_ready); end
    tick; req_valid = '0;
    tick; tick; settle;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rmw_rsp_valid: got %b expected 0001", rsp_valid); end
    checks++; if (rsp_data !== 16'h40DE) begin errors++; $display("FAIL rmw_rsp_data: got %h expected 40de", rsp_data); end
    tick; settle;
  endtask

`ifdef NEG_UNIT_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    model_en = 1'b0;
    req_data[1*DATA_W +: DATA_W] = 16'h1111;
    req_valid = 4'b0010; rsp_ready = 4'hF;
    settle;
    tick; req_valid = '0;
    tick;
    repeat (14) tick;
    settle;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL to_early: got %b expected 0000", rsp_valid); end
    tick; settle;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL to_rsp_valid: got %b expected 0010", rsp_valid); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL to_rsp_err: got %b expected 1", rsp_err); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL to_rsp_data: got %h expected 0000", rsp_data); end
    tick; settle;
    model_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_backpressure;
    test_spurious;
    test_reset_mid_wait;
`ifdef NEG_UNIT_SCHED_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/neg_unit_sched.md
# neg_unit_sched

Round-robin scheduler sharing one 16-bit sign-inversion (FP16 negate) unit between NUM_REQ requesters in the VCU datapath. Each request is granted, issued to the unit as a single-cycle valid pulse, and the unit's one-cycle `complete` is awaited. The result is returned to the owning requester under a valid/ready handshake. One operation is in flight at a time.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, operand/result width
- TIMEOUT, 15, max WAIT cycles before error response (only with macro)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; held until granted
- req_data  in  NUM_REQ*DATA_W  flattened operands; slice i = [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant/accept pulse
- rsp_valid  out  NUM_REQ  one-hot response valid to owner
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  DATA_W  shared response bus, meaningful only with rsp_valid
- rsp_err  out  1  response is a timeout (0 without macro)
- unit_data  out  DATA_W  operand to negate unit (registered)
- unit_valid  out  1  single-cycle issue strobe to unit
- unit_result  in  DATA_W  unit result
- unit_complete  in  1  unit done pulse

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant g = first set bit searching from ptr upward, wrapping mod NUM_REQ. Same cycle: req_ready[g]=1 (combinational), unit_data<=req_data[g], owner<=g, go to ISSUE. No valid: stay.
- ISSUE: unit_valid=1 for exactly this cycle; go to WAIT.
- WAIT: on unit_complete, rsp_data<=unit_result, rsp_err<=0, go to RESP.
- RESP: rsp_valid[owner]=1, rsp_data stable; on rsp_ready[owner], ptr<=(owner+1) mod NUM_REQ, go to IDLE.
- unit_complete outside WAIT is ignored.
- A requester deasserting req_valid before req_ready is a protocol violation; the scheduler's behaviour then is undefined.
- rsp_ready of non-owners is ignored.
- Reset (async, any state): state=IDLE, ptr=0, owner=0, unit_data=0, rsp_data=0, rsp_err=0. Outputs req_ready, rsp_valid, unit_valid are 0. The in-flight operation is dropped; a late unit_complete after reset is ignored.

## Timing
- Grant cycle T (IDLE): req_ready high in T. unit_valid is high in T+1. With the standard unit, unit_complete is high in T+2. rsp_valid is high from T+3.
- Minimum 4 cycles per operation. With rsp_ready held high, the next grant occurs in T+4.
- unit_valid is never asserted on consecutive cycles.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 operations.

## Configuration
- NEG_UNIT_SCHED_TIMEOUT_EN defined: a 4-bit+ counter clears on entering WAIT and increments each WAIT cycle without unit_complete. When it reaches TIMEOUT: rsp_data<=0, rsp_err<=1, go to RESP. If unit_complete and the timeout coincide, the complete wins (rsp_err=0).
- Undefined: no counter; WAIT waits indefinitely; rsp_err is constant 0.

## Structure
- Package neg_unit_sched_pkg: state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, RESP=3), default DATA_W, NUM_REQ, TIMEOUT.
- Sub-module rr_arb: a combinational round-robin priority picker. Inputs: request vector and ptr. Outputs: one-hot grant and index.

## Test plan
- Single request: port 2 sends 16'h3C00, rsp_ready=1 → req_ready[2] in T, unit_valid in T+1, rsp_valid[2] in T+3 with rsp_data=16'hBC00, rsp_err=0.
- Round-robin: all 4 ports valid continuously (data 16'h0001..16'h0004) → grants in order 0,1,2,3,0. Responses are 16'h8001..16'h8004, each to its owner.
- Backpressure: rsp_ready[1]=0 for 5 cycles → rsp_valid[1] and rsp_data held stable, no new grant. Release → IDLE the next cycle.
- Spurious complete: pulse unit_complete in IDLE and in RESP → no state change, rsp_data unchanged.
- Reset mid-WAIT: assert rst asynchronously → all outputs 0 immediately, ptr=0. After release, port 0 wins the first grant.
- Timeout (macro on, TIMEOUT=15): unit never completes → rsp_valid with rsp_err=1 and rsp_data=16'h0000, 15 cycles after entering WAIT.
